// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS subset datapath
// (addu, subu, ori, lui, lw, sw, beq, j). Outputs are decoded from the
// registered state plus the latched opcode/funct, so one ALU and one memory
// port can serve fetch, execute and memory phases.
// Optional build macro DM_WAIT_EN: adds a dm_ready input and makes the
// memory states wait for it.
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
`ifdef DM_WAIT_EN
    input  logic       dm_ready,
`endif
    output logic       pc_wr,
    output logic       ir_wr,
    output logic [1:0] npc_sel,
    output logic       reg_dst,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic       ext_op,
    output logic       mem_to_reg,
    output logic       reg_wr,
    output logic       mem_wr,
    output logic       instr_done,
    output logic [3:0] state
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXE    = 4'd2,
        S_MEM_RD = 4'd3,
        S_MEM_WR = 4'd4,
        S_WB_R   = 4'd5,
        S_WB_I   = 4'd6,
        S_WB_MEM = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    state_t state_q;
    state_t state_d;

    logic       is_r_alu;
    logic       is_ori;
    logic       is_lui;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_j;
    logic       uses_exe;
    logic [2:0] alu_op_i;
    logic       alu_src_i;
    logic       ext_op_i;

    // Instruction class and the ALU controls it needs while the ALU result is live
    always_comb begin
        is_r_alu  = (opcode == OP_R) && ((funct == FN_ADDU) || (funct == FN_SUBU));
        is_ori    = (opcode == OP_ORI);
        is_lui    = (opcode == OP_LUI);
        is_lw     = (opcode == OP_LW);
        is_sw     = (opcode == OP_SW);
        is_beq    = (opcode == OP_BEQ);
        is_j      = (opcode == OP_J);
        uses_exe  = is_r_alu || is_ori || is_lui || is_lw || is_sw;
        alu_src_i = is_ori || is_lui || is_lw || is_sw;
        ext_op_i  = is_lw || is_sw;
        alu_op_i  = ALU_ADD;
        if ((opcode == OP_R) && (funct == FN_SUBU)) begin
            alu_op_i = ALU_SUB;
        end else if (is_ori) begin
            alu_op_i = ALU_OR;
        end else if (is_lui) begin
            alu_op_i = ALU_LUI;
        end
    end

    // State register; reset returns the sequencer to FETCH
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state enables; everything is held low while reset is high
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        npc_sel    = NPC_SEQ;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        ext_op     = 1'b0;
        mem_to_reg = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ir_wr   = 1'b1;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    if (uses_exe) begin
                        state_d = S_EXE;
                    end else if (is_beq) begin
                        state_d = S_BRANCH;
                    end else if (is_j) begin
                        state_d = S_JUMP;
                    end else begin
                        // Unsupported: refetch the same PC
                        state_d = S_FETCH;
                    end
                end
                S_EXE: begin
                    alu_src = alu_src_i;
                    alu_op  = alu_op_i;
                    ext_op  = ext_op_i;
                    if (is_r_alu) begin
                        state_d = S_WB_R;
                    end else if (is_ori || is_lui) begin
                        state_d = S_WB_I;
                    end else if (is_lw) begin
                        state_d = S_MEM_RD;
                    end else if (is_sw) begin
                        state_d = S_MEM_WR;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_WB_R: begin
                    alu_src = alu_src_i;
                    alu_op  = alu_op_i;
                    ext_op  = ext_op_i;
                    reg_dst = 1'b1;
                    reg_wr  = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = S_FETCH;
                end
                S_WB_I: begin
                    alu_src = alu_src_i;
                    alu_op  = alu_op_i;
                    ext_op  = ext_op_i;
                    reg_wr  = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = S_FETCH;
                end
                S_MEM_RD: begin
                    alu_src = alu_src_i;
                    alu_op  = alu_op_i;
                    ext_op  = ext_op_i;
`ifdef DM_WAIT_EN
                    if (dm_ready) begin
                        state_d = S_WB_MEM;
                    end
`else
                    state_d = S_WB_MEM;
`endif
                end
                S_WB_MEM: begin
                    mem_to_reg = 1'b1;
                    reg_wr     = 1'b1;
                    pc_wr      = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEM_WR: begin
                    alu_src = alu_src_i;
                    alu_op  = alu_op_i;
                    ext_op  = ext_op_i;
                    mem_wr  = 1'b1;
`ifdef DM_WAIT_EN
                    if (dm_ready) begin
                        pc_wr   = 1'b1;
                        state_d = S_FETCH;
                    end
`else
                    pc_wr   = 1'b1;
                    state_d = S_FETCH;
`endif
                end
                S_BRANCH: begin
                    alu_op  = ALU_SUB;
                    ext_op  = 1'b1;
                    pc_wr   = 1'b1;
                    npc_sel = zero ? NPC_BR : NPC_SEQ;
                    state_d = S_FETCH;
                end
                S_JUMP: begin
                    pc_wr   = 1'b1;
                    npc_sel = NPC_J;
                    state_d = S_FETCH;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    assign instr_done = pc_wr;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl. A per-instruction phase model
// predicts the full output vector every cycle; directed cases cover reset,
// each instruction class and branch/jump/unsupported paths, followed by a
// random instruction stream. Build with DM_WAIT_EN defined to exercise waits.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
`ifdef DM_WAIT_EN
    logic       dm_ready;
`endif
    logic       pc_wr;
    logic       ir_wr;
    logic [1:0] npc_sel;
    logic       reg_dst;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       ext_op;
    logic       mem_to_reg;
    logic       reg_wr;
    logic       mem_wr;
    logic       instr_done;
    logic [3:0] state;

    int checks = 0;
    int passes = 0;

    typedef enum {C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_BAD} cls_t;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_wr;
        logic       ir_wr;
        logic [1:0] npc_sel;
        logic       reg_dst;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       ext_op;
        logic       mem_to_reg;
        logic       reg_wr;
        logic       mem_wr;
        logic       instr_done;
    } obs_t;

    obs_t obs;
    assign obs = {state, pc_wr, ir_wr, npc_sel, reg_dst, alu_src, alu_op,
                  ext_op, mem_to_reg, reg_wr, mem_wr, instr_done};

    mc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
`ifdef DM_WAIT_EN
        .dm_ready   (dm_ready),
`endif
        .pc_wr      (pc_wr),
        .ir_wr      (ir_wr),
        .npc_sel    (npc_sel),
        .reg_dst    (reg_dst),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .ext_op     (ext_op),
        .mem_to_reg (mem_to_reg),
        .reg_wr     (reg_wr),
        .mem_wr     (mem_wr),
        .instr_done (instr_done),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Instruction class straight from the opcode/funct table
    function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00 && fn == 6'h21) return C_ADDU;
        if (op == 6'h00 && fn == 6'h23) return C_SUBU;
        if (op == 6'h0D) return C_ORI;
        if (op == 6'h0F) return C_LUI;
        if (op == 6'h23) return C_LW;
        if (op == 6'h2B) return C_SW;
        if (op == 6'h04) return C_BEQ;
        if (op == 6'h02) return C_J;
        return C_BAD;
    endfunction

    // Expected outputs for one cycle spent in phase ph while executing class c
    function automatic obs_t expect_out(input int ph, input cls_t c,
                                        input logic z, input logic rdy);
        obs_t e;
        logic       a_src;
        logic [2:0] a_op;
        logic       a_ext;
        e     = '0;
        e.st  = 4'(ph);
        a_src = (c == C_ORI) || (c == C_LUI) || (c == C_LW) || (c == C_SW);
        a_ext = (c == C_LW) || (c == C_SW);
        a_op  = (c == C_SUBU) ? 3'd1 : (c == C_ORI) ? 3'd2 : (c == C_LUI) ? 3'd3 : 3'd0;
        if (ph inside {2, 3, 4, 5, 6}) begin
            e.alu_src = a_src;
            e.alu_op  = a_op;
            e.ext_op  = a_ext;
        end
        case (ph)
            0: e.ir_wr = 1'b1;
            4: begin e.mem_wr = 1'b1; e.pc_wr = rdy; end
            5: begin e.reg_dst = 1'b1; e.reg_wr = 1'b1; e.pc_wr = 1'b1; end
            6: begin e.reg_wr = 1'b1; e.pc_wr = 1'b1; end
            7: begin e.mem_to_reg = 1'b1; e.reg_wr = 1'b1; e.pc_wr = 1'b1; end
            8: begin
                e.alu_op  = 3'd1;
                e.ext_op  = 1'b1;
                e.pc_wr   = 1'b1;
                e.npc_sel = z ? 2'b01 : 2'b00;
            end
            9: begin e.pc_wr = 1'b1; e.npc_sel = 2'b10; end
            default: ;
        endcase
        e.instr_done = e.pc_wr;
        return e;
    endfunction

    // One cycle: compare at the falling edge, then advance past the rising edge
    task automatic step(input string tag, input obs_t exp);
        @(negedge clk);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    // Run one full instruction; zsel 2 = random zero, else its LSB; rdy_lo < 0 = random memory waits
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int zsel, input int rdy_lo);
        cls_t c;
        int   phases[$];
        int   waits;
        logic rdy;
        opcode = op;
        funct  = fn;
        c      = classify(op, fn);
        phases = '{0, 1};
        case (c)
            C_ADDU, C_SUBU: phases = '{0, 1, 2, 5};
            C_ORI,  C_LUI:  phases = '{0, 1, 2, 6};
            C_LW:           phases = '{0, 1, 2, 3, 7};
            C_SW:           phases = '{0, 1, 2, 4};
            C_BEQ:          phases = '{0, 1, 8};
            C_J:            phases = '{0, 1, 9};
            default:        phases = '{0, 1};
        endcase
        foreach (phases[k]) begin
            waits = 0;
            forever begin
                zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : (zsel != 0);
`ifdef DM_WAIT_EN
                if (rdy_lo >= 0) dm_ready = (waits >= rdy_lo);
                else             dm_ready = (waits >= 6) || ($urandom_range(0, 1) == 1);
                rdy = (phases[k] == 3 || phases[k] == 4) ? dm_ready : 1'b1;
`else
                rdy = 1'b1;
`endif
                step($sformatf("%s ph%0d w%0d", c.name(), phases[k], waits),
                     expect_out(phases[k], c, zero, rdy));
                if (rdy) break;
                waits++;
            end
        end
        if (rdy_lo > 1000) $display("note: unusual wait request %0d", rdy_lo);
    endtask

    initial begin
        obs_t e;
        logic [5:0] op;
        logic [5:0] fn;
        reset  = 1'b1;
        opcode = 6'h00;
        funct  = 6'h00;
        zero   = 1'b0;
`ifdef DM_WAIT_EN
        dm_ready = 1'b1;
`endif
        @(posedge clk);
        #1;
        // Reset holds FETCH with every output low
        step("reset_idle", '0);
        reset = 1'b0;

        // addu interrupted by a two-cycle reset while in EXE
        opcode = 6'h00;
        funct  = 6'h21;
        step("rst_addu ph0", expect_out(0, C_ADDU, 1'b0, 1'b1));
        step("rst_addu ph1", expect_out(1, C_ADDU, 1'b0, 1'b1));
        reset = 1'b1;
        e = '0;
        e.st = 4'd2;
        step("rst_in_exe", e);
        step("rst_cycle1", '0);
        reset = 1'b0;

        // Directed: each class once, both branch outcomes, unsupported encodings
        run_instr(6'h00, 6'h21, 2, 0);
        run_instr(6'h00, 6'h23, 2, 0);
        run_instr(6'h0D, 6'h15, 2, 0);
        run_instr(6'h0F, 6'h3F, 2, 0);
        run_instr(6'h23, 6'h00, 2, 0);
        run_instr(6'h2B, 6'h21, 2, 0);
        run_instr(6'h04, 6'h00, 1, 0);
        run_instr(6'h04, 6'h00, 0, 0);
        run_instr(6'h02, 6'h00, 2, 0);
        run_instr(6'h3F, 6'h21, 2, 0);
        run_instr(6'h00, 6'h20, 2, 0);
`ifdef DM_WAIT_EN
        // sw with dm_ready low for three cycles, then lw with two waits
        run_instr(6'h2B, 6'h00, 2, 3);
        run_instr(6'h23, 6'h00, 2, 2);
`endif

        // Random instruction stream
        for (int n = 0; n < 300; n++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 9))
                0: begin op = 6'h00; fn = 6'h21; end
                1: begin op = 6'h00; fn = 6'h23; end
                2: op = 6'h0D;
                3: op = 6'h0F;
                4: op = 6'h23;
                5: op = 6'h2B;
                6: op = 6'h04;
                7: op = 6'h02;
                8: op = 6'($urandom);
                default: op = 6'h00;
            endcase
            run_instr(op, fn, 2, -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
